usb_tx_packetizer: RTL
======================

Name: usb_tx_packetizer

Overview:
- Parametrised byte-level transmit sequencer for the USB full-speed device TX path.
- Frames a packet as SYNC, PID, optional payload and CRC16, then EOP. Supports DATA0/DATA1 with payloads of 0..MAX_DATA_BYTES, and ACK/NAK/STALL handshakes.
- Hands bytes to the downstream parallel-to-serial shifter/NRZI encoder and drives the SE0/J EOP signalling itself.
- Sits between the TX data buffer and the serializer, replacing the fixed single-mode TX controller.

Parameters:
- MAX_DATA_BYTES, 64, largest payload accepted.
- LEN_W, 7, width of tx_len; must satisfy 2**LEN_W > MAX_DATA_BYTES.
- BIT_CYCLES, 8, clk cycles per USB bit time; used only for EOP timing.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tx_start  in  1  one-cycle request to send a packet.
- tx_pid_sel  in  3  packet type: 0 DATA0, 1 DATA1, 2 ACK, 3 NAK, 4 STALL; 5-7 invalid.
- tx_len  in  LEN_W  payload byte count, DATA only.
- data_in  in  8  payload byte from TX buffer.
- data_valid  in  1  data_in holds a byte.
- data_ready  out  1  pop strobe to TX buffer (combinational).
- crc_in  in  16  externally computed CRC16, already complemented.
- byte_req  in  1  serializer pulse: previous byte fully shifted, ready for the next.
- load_en  out  1  one-cycle load strobe to the shifter.
- load_byte  out  8  byte to load, valid while load_en=1.
- eop_active  out  1  encoder drives SE0 while high.
- eop_j  out  1  encoder drives J while high.
- busy  out  1  packet in progress.
- tx_done  out  1  one-cycle pulse when a packet completes.
- tx_err  out  1  one-cycle pulse on rejected start or payload underrun.
- state_code  out  4  current state encoding, for debug.

Behaviour:
- Reset is asynchronous and active-high. State goes to IDLE. All registered outputs go to 0, including load_byte, and byte and EOP counters clear. Reset mid-packet aborts the packet immediately; no EOP is emitted.
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
- IDLE, tx_start=1:
  - Valid pid_sel with (pid_sel>1 or tx_len<=MAX_DATA_BYTES): latch pid_sel and tx_len, go to SYNC, busy=1 next cycle.
  - Otherwise pulse tx_err and stay in IDLE.
- tx_start while busy is ignored.
- SYNC: load_en=1 with load_byte=0x80 in the first cycle of SYNC, one cycle after tx_start. Each later byte is loaded the cycle after byte_req is sampled high.
- PID bytes (LSB-first): DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
- Transitions after PID load, on the next byte_req:
  - handshake goes to EOP_SE0;
  - DATA with len=0 goes to CRC_LO;
  - otherwise goes to DATA.
- DATA, on byte_req:
  - data_valid=1: data_ready=1 that cycle, data_in loaded, count++. When count==len, go to CRC_LO at the next byte_req.
  - data_valid=0 (underrun): pulse tx_err, go directly to EOP_SE0; tx_done is still pulsed at the end.
- CRC_LO loads crc_in[7:0]; CRC_HI loads crc_in[15:8]. The next byte_req goes to EOP_SE0.
- EOP_SE0: eop_active=1 for exactly 2*BIT_CYCLES cycles.
- EOP_J: eop_j=1 for BIT_CYCLES cycles. On the last cycle tx_done=1; return to IDLE and clear busy.
- The byte counter is LEN_W+1 bits wide; it cannot wrap because tx_len is bounded at start.
- byte_req outside SYNC..CRC_HI is ignored. byte_req in the same cycle as a load is impossible by the serializer contract; if it occurs, it is ignored.
- data_ready is 0 in every state except DATA.

Optional Feature:
- Macro: USB_TX_CRC16_EN.
- Defined:
  - Internal reflected CRC16: poly 0xA001, init 0xFFFF, updated on each payload byte loaded.
  - The CRC bytes sent are the complement, low byte first.
  - crc_in is ignored.
  - A zero-length packet sends 0x00, 0x00.
- Undefined: crc_in is sent verbatim as described under Behaviour, and no CRC logic is synthesised.

Decomposition:
- Package usb_tx_pkg holds:
  - the tx_pid_sel enum;
  - PID byte constants;
  - SYNC_BYTE = 0x80;
  - the state enum, whose values are the state_code encodings.
- Sub-module usb_crc16: byte-wide combinational/registered CRC16 update, with clear and enable. It is instantiated only under USB_TX_CRC16_EN.

Test Plan:
- ACK request (pid_sel=2). Required:
  - loads 0x80 then 0xD2;
  - eop_active high for 16 cycles, then eop_j for 8;
  - tx_done pulses once, busy falls.
- DATA1, len=3, buffer holding 0x11, 0x22, 0x33, crc_in=0xBEEF, macro off. Required:
  - load sequence 0x80, 0x4B, 0x11, 0x22, 0x33, 0xEF, 0xBE;
  - exactly 3 data_ready pulses.
- DATA0, len=0. Required: loads 0x80, 0xC3, then CRC bytes (0x00, 0x00 with macro; crc_in bytes without), then EOP.
- DATA0, len=4, data_valid dropped before the 3rd byte. Required:
  - tx_err pulse;
  - no CRC loads;
  - EOP then tx_done.
- Invalid starts:
  - pid_sel=6: tx_err, stays IDLE;
  - tx_len=65: tx_err, stays IDLE;
  - second tx_start during a packet: no effect.
- Reset asserted mid-DATA. Required:
  - all outputs 0 immediately;
  - a new ACK after release completes normally;
  - macro-on 1-byte payload CRC matches the reference model.

Source files
------------

// File: rtl/usb_tx_packetizer_pkg.sv
// rtl/usb_tx_packetizer_pkg.sv - shared types and constants for the USB full-speed TX packetizer
// Contents: tx_pid_sel enum, PID byte constants, SYNC_BYTE, state enum (values are state_code)
package usb_tx_pkg;

    typedef enum logic [2:0] {
        PID_DATA0 = 3'd0,
        PID_DATA1 = 3'd1,
        PID_ACK   = 3'd2,
        PID_NAK   = 3'd3,
        PID_STALL = 3'd4
    } pid_sel_e;

    localparam logic [7:0] SYNC_BYTE       = 8'h80;
    localparam logic [7:0] PID_BYTE_DATA0  = 8'hC3;
    localparam logic [7:0] PID_BYTE_DATA1  = 8'h4B;
    localparam logic [7:0] PID_BYTE_ACK    = 8'hD2;
    localparam logic [7:0] PID_BYTE_NAK    = 8'h5A;
    localparam logic [7:0] PID_BYTE_STALL  = 8'h1E;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SYNC    = 4'd1,
        ST_PID     = 4'd2,
        ST_DATA    = 4'd3,
        ST_CRC_LO  = 4'd4,
        ST_CRC_HI  = 4'd5,
        ST_EOP_SE0 = 4'd6,
        ST_EOP_J   = 4'd7
    } state_e;

    // PID byte as it goes on the wire (LSB-first shifter); caller guarantees sel <= 4
    function automatic logic [7:0] pid_byte(input logic [2:0] sel);
        case (sel)
            PID_DATA0: return PID_BYTE_DATA0;
            PID_DATA1: return PID_BYTE_DATA1;
            PID_ACK:   return PID_BYTE_ACK;
            PID_NAK:   return PID_BYTE_NAK;
            default:   return PID_BYTE_STALL;
        endcase
    endfunction

    function automatic logic pid_is_data(input logic [2:0] sel);
        return (sel == PID_DATA0) || (sel == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_tx_packetizer_if.sv
// rtl/usb_tx_packetizer_if.sv - request, TX-buffer and serializer signals of the USB TX packetizer
// Modports: slave = packetizer side, master = requester/buffer/serializer side
interface usb_tx_packetizer_if #(
    parameter int LEN_W = 7
);
    logic             tx_start;
    logic [2:0]       tx_pid_sel;
    logic [LEN_W-1:0] tx_len;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             data_ready;
    logic [15:0]      crc_in;
    logic             byte_req;
    logic             load_en;
    logic [7:0]       load_byte;
    logic             eop_active;
    logic             eop_j;
    logic             busy;
    logic             tx_done;
    logic             tx_err;
    logic [3:0]       state_code;

    modport slave (
        input  tx_start, tx_pid_sel, tx_len, data_in, data_valid, crc_in, byte_req,
        output data_ready, load_en, load_byte, eop_active, eop_j, busy, tx_done, tx_err, state_code
    );

    modport master (
        output tx_start, tx_pid_sel, tx_len, data_in, data_valid, crc_in, byte_req,
        input  data_ready, load_en, load_byte, eop_active, eop_j, busy, tx_done, tx_err, state_code
    );
endinterface

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - byte-wide reflected CRC16 (poly 0xA001, init 0xFFFF) with clear and enable
// Ports: clk, rst (async high), clr (reload init), en (absorb data), data[7:0], crc[15:0] (uncomplemented)
// Built only when USB_TX_CRC16_EN is defined.
`ifdef USB_TX_CRC16_EN
module usb_crc16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 16'hFFFF;
        end else if (clr) begin
            crc <= 16'hFFFF;
        end else if (en) begin
            crc <= crc16_byte(crc, data);
        end
    end
endmodule
`endif

// File: rtl/usb_tx_packetizer.sv
// rtl/usb_tx_packetizer.sv - byte-level USB full-speed TX sequencer: SYNC, PID, payload, CRC16, EOP
// Ports: clk, rst (async active-high), bus (usb_tx_packetizer_if.slave: start/pid/len request,
//        data_in/data_valid/data_ready buffer pop, crc_in, byte_req/load_en/load_byte shifter,
//        eop_active/eop_j line drive, busy/tx_done/tx_err/state_code status)
// Option: USB_TX_CRC16_EN - CRC computed internally over the payload instead of taken from crc_in.
module usb_tx_packetizer
    import usb_tx_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64,
    parameter int LEN_W          = 7,
    parameter int BIT_CYCLES     = 8
) (
    input  logic clk,
    input  logic rst,
    usb_tx_packetizer_if.slave bus
);
    localparam int EOP_W = $clog2(2 * BIT_CYCLES + 1);
    localparam logic [EOP_W-1:0] SE0_LAST = EOP_W'(2 * BIT_CYCLES - 1);
    localparam logic [EOP_W-1:0] J_LAST   = EOP_W'(BIT_CYCLES - 1);
    localparam logic [LEN_W:0]   MAX_LEN  = (LEN_W + 1)'(MAX_DATA_BYTES);

    state_e           state;
    logic [2:0]       pid_q;
    logic [LEN_W:0]   len_q;
    logic [LEN_W:0]   count;
    logic [EOP_W-1:0] eop_cnt;
    logic             load_en_q;
    logic [7:0]       load_byte_q;
    logic             eop_active_q;
    logic             eop_j_q;
    logic             busy_q;
    logic             tx_done_q;
    logic             tx_err_q;

    logic             req_ok;
    logic             start_ok;
    logic             data_pop;
    logic [15:0]      crc_tx;

    // A byte_req landing on a load cycle violates the serializer contract and is dropped.
    assign req_ok   = bus.byte_req & ~load_en_q;
    assign start_ok = (bus.tx_pid_sel <= 3'd4) &&
                      ((bus.tx_pid_sel > 3'd1) || ({1'b0, bus.tx_len} <= MAX_LEN));
    assign data_pop = (state == ST_DATA) && req_ok && (count != len_q) && bus.data_valid;

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_q;
    logic        unused_crc_in;

    usb_crc16 u_crc16 (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == ST_IDLE),
        .en   (data_pop),
        .data (bus.data_in),
        .crc  (crc_q)
    );

    assign crc_tx        = ~crc_q;
    assign unused_crc_in = ^bus.crc_in;
`else
    assign crc_tx = bus.crc_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            pid_q        <= 3'd0;
            len_q        <= '0;
            count        <= '0;
            eop_cnt      <= '0;
            load_en_q    <= 1'b0;
            load_byte_q  <= 8'h00;
            eop_active_q <= 1'b0;
            eop_j_q      <= 1'b0;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_err_q     <= 1'b0;
        end else begin
            load_en_q <= 1'b0;
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.tx_start) begin
                        if (start_ok) begin
                            state       <= ST_SYNC;
                            busy_q      <= 1'b1;
                            pid_q       <= bus.tx_pid_sel;
                            len_q       <= {1'b0, bus.tx_len};
                            count       <= '0;
                            load_en_q   <= 1'b1;
                            load_byte_q <= SYNC_BYTE;
                        end else begin
                            tx_err_q <= 1'b1;
                        end
                    end
                end
                ST_SYNC: begin
                    if (req_ok) begin
                        state       <= ST_PID;
                        load_en_q   <= 1'b1;
                        load_byte_q <= pid_byte(pid_q);
                    end
                end
                ST_PID: begin
                    if (req_ok) begin
                        if (!pid_is_data(pid_q)) begin
                            state        <= ST_EOP_SE0;
                            eop_active_q <= 1'b1;
                            eop_cnt      <= '0;
                        end else if (len_q == '0) begin
                            state       <= ST_CRC_LO;
                            load_en_q   <= 1'b1;
                            load_byte_q <= crc_tx[7:0];
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (req_ok) begin
                        if (count == len_q) begin
                            state       <= ST_CRC_LO;
                            load_en_q   <= 1'b1;
                            load_byte_q <= crc_tx[7:0];
                        end else if (bus.data_valid) begin
                            load_en_q   <= 1'b1;
                            load_byte_q <= bus.data_in;
                            count       <= count + 1'b1;
                        end else begin
                            // Underrun: abandon the payload, close the packet with EOP.
                            tx_err_q     <= 1'b1;
                            state        <= ST_EOP_SE0;
                            eop_active_q <= 1'b1;
                            eop_cnt      <= '0;
                        end
                    end
                end
                ST_CRC_LO: begin
                    if (req_ok) begin
                        state       <= ST_CRC_HI;
                        load_en_q   <= 1'b1;
                        load_byte_q <= crc_tx[15:8];
                    end
                end
                ST_CRC_HI: begin
                    if (req_ok) begin
                        state        <= ST_EOP_SE0;
                        eop_active_q <= 1'b1;
                        eop_cnt      <= '0;
                    end
                end
                ST_EOP_SE0: begin
                    if (eop_cnt == SE0_LAST) begin
                        state        <= ST_EOP_J;
                        eop_active_q <= 1'b0;
                        eop_j_q      <= 1'b1;
                        eop_cnt      <= '0;
                        tx_done_q    <= (BIT_CYCLES == 1);
                    end else begin
                        eop_cnt <= eop_cnt + 1'b1;
                    end
                end
                ST_EOP_J: begin
                    if (eop_cnt == J_LAST) begin
                        state   <= ST_IDLE;
                        eop_j_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        eop_cnt <= eop_cnt + 1'b1;
                        // tx_done is registered, so raise it one cycle early to land on the last J cycle.
                        tx_done_q <= ((eop_cnt + 1'b1) == J_LAST);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_ready = data_pop;
    assign bus.load_en    = load_en_q;
    assign bus.load_byte  = load_byte_q;
    assign bus.eop_active = eop_active_q;
    assign bus.eop_j      = eop_j_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.tx_err     = tx_err_q;
    assign bus.state_code = state;

endmodule
